// File: rtl/util_cpackn_timestamp.sv
// Channel packer for the ADC RX path: packs enabled-channel samples into DATA_W beats
// and prefixes each block of timestamp_every data beats with a timestamp header beat.
module util_cpackn_timestamp #(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 16,
    parameter int DATA_W   = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            timestamp,
    input  logic [31:0]                  timestamp_every,
    input  logic [NUM_CH-1:0]            enable,
    input  logic                         fifo_wr_en,
    input  logic [NUM_CH*SAMPLE_W-1:0]   fifo_wr_data,
    output logic                         fifo_wr_overflow,
    output logic                         packed_fifo_wr_en,
    output logic                         packed_fifo_wr_sync,
    output logic                         packed_fifo_wr_ts,
    output logic [DATA_W-1:0]            packed_fifo_wr_data,
    input  logic                         packed_fifo_wr_overflow
);

    localparam int LANES  = DATA_W / SAMPLE_W;
    localparam int LANE_W = $clog2(LANES);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_STORE} state_t;

    state_t                     r_state, w_state_next;
    logic [NUM_CH-1:0]          r_enable;
    logic [CNT_W-1:0]           w_enable_count;
    logic [CH_W-1:0]            w_map [NUM_CH];
    logic [CH_W-1:0]            r_chan_idx;
    logic [LANE_W-1:0]          r_lane_idx;
    logic [NUM_CH*SAMPLE_W-1:0] r_sample_hold;
    logic [SAMPLE_W-1:0]        w_sample;
    logic [DATA_W-1:0]          r_pack, w_pack_next, r_ts_hold;
    logic [31:0]                r_beat_cnt, r_blk_len;
    logic                       r_hdr_pend, r_lane0_first, r_ovf;
    logic                       w_en_change, w_init, w_accept, w_store, w_ovf;
    logic                       w_blk_start, w_last_chan, w_beat_done;

    assign w_en_change      = (enable != r_enable);
    assign w_last_chan      = (int'(r_chan_idx) + 1 == int'(w_enable_count));
    assign fifo_wr_overflow = packed_fifo_wr_overflow | r_ovf;

    // w_map[k] is the channel number of the k-th enabled channel in ascending order
    always_comb begin
        int unsigned k;
        k = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) w_map[i] = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (r_enable[ch]) begin
                w_map[k[CH_W-1:0]] = CH_W'(ch);
                k = k + 1;
            end
        end
        w_enable_count = CNT_W'(k);
    end

    always_comb begin
        w_sample = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            if (CH_W'(ch) == w_map[r_chan_idx]) w_sample = r_sample_hold[ch*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_comb begin
        w_pack_next = r_pack;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (LANE_W'(l) == r_lane_idx) w_pack_next[l*SAMPLE_W +: SAMPLE_W] = w_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_en_change) begin
            w_state_next = ST_INIT;
        end else begin
            case (r_state)
                ST_INIT:  w_state_next = ST_IDLE;
                ST_IDLE:  if (w_accept) w_state_next = ST_STORE;
                ST_STORE: if (w_last_chan) w_state_next = ST_IDLE;
                default:  w_state_next = ST_INIT;
            endcase
        end
    end

    // An enable change pre-empts whatever the current state would have done this cycle
    always_comb begin
        w_init   = 1'b0;
        w_accept = 1'b0;
        w_store  = 1'b0;
        w_ovf    = fifo_wr_en && (r_state != ST_IDLE);
        if (!w_en_change) begin
            case (r_state)
                ST_INIT:  w_init   = 1'b1;
                ST_IDLE:  w_accept = fifo_wr_en && (w_enable_count != '0);
                ST_STORE: w_store  = 1'b1;
                default:  ;
            endcase
        end
        w_blk_start = w_accept && (r_chan_idx == '0) && (r_lane_idx == '0) &&
                      (r_beat_cnt == '0) && (timestamp_every != '0);
        w_beat_done = w_store && (r_lane_idx == LANE_W'(LANES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable            <= '0;
            r_chan_idx          <= '0;
            r_lane_idx          <= '0;
            r_sample_hold       <= '0;
            r_pack              <= '0;
            r_ts_hold           <= '0;
            r_beat_cnt          <= '0;
            r_blk_len           <= '0;
            r_hdr_pend          <= 1'b0;
            r_lane0_first       <= 1'b0;
            r_ovf               <= 1'b0;
            packed_fifo_wr_en   <= 1'b0;
            packed_fifo_wr_sync <= 1'b0;
            packed_fifo_wr_ts   <= 1'b0;
            packed_fifo_wr_data <= '0;
        end else begin
            r_enable            <= enable;
            r_ovf               <= w_ovf;
            packed_fifo_wr_en   <= 1'b0;
            packed_fifo_wr_sync <= 1'b0;
            packed_fifo_wr_ts   <= 1'b0;
            if (w_en_change || w_init) begin
                r_chan_idx <= '0;
                r_lane_idx <= '0;
            end
            if (w_en_change) begin
                r_beat_cnt <= '0;
                r_blk_len  <= '0;
                r_hdr_pend <= 1'b0;
            end
            if (w_accept) begin
                r_sample_hold <= fifo_wr_data;
                if (w_blk_start) begin
                    r_ts_hold  <= timestamp;
                    r_blk_len  <= timestamp_every;
                    r_hdr_pend <= 1'b1;
                end
            end
            if (w_store) begin
                r_pack     <= w_pack_next;
                r_chan_idx <= w_last_chan ? '0 : r_chan_idx + CH_W'(1);
                r_lane_idx <= w_beat_done ? '0 : r_lane_idx + LANE_W'(1);
                if (r_lane_idx == '0) r_lane0_first <= (r_chan_idx == '0);
                // Header goes out on the lane-0 store, so it can never meet a data beat
                if (r_hdr_pend) begin
                    r_hdr_pend          <= 1'b0;
                    packed_fifo_wr_en   <= 1'b1;
                    packed_fifo_wr_ts   <= 1'b1;
                    packed_fifo_wr_sync <= 1'b1;
                    packed_fifo_wr_data <= r_ts_hold;
                end
                if (w_beat_done) begin
                    packed_fifo_wr_en   <= 1'b1;
                    packed_fifo_wr_sync <= (timestamp_every == '0) && r_lane0_first;
                    packed_fifo_wr_data <= w_pack_next;
                    if (r_blk_len != '0) begin
                        if (r_beat_cnt + 32'd1 == r_blk_len) begin
                            r_beat_cnt <= '0;
                            r_blk_len  <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 32'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_util_cpackn_timestamp.sv
// Directed bench for util_cpackn_timestamp: a beat/overflow model built from accepted
// sample sets is checked against the DUT every cycle, plus literal pins on observed beats.
module tb_util_cpackn_timestamp;

    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 16;
    localparam int DATA_W   = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] timestamp;
    logic [31:0] timestamp_every;
    logic [3:0]  enable;
    logic        fifo_wr_en;
    logic [63:0] fifo_wr_data;
    logic        fifo_wr_overflow;
    logic        packed_fifo_wr_en;
    logic        packed_fifo_wr_sync;
    logic        packed_fifo_wr_ts;
    logic [63:0] packed_fifo_wr_data;
    logic        packed_fifo_wr_overflow;

    util_cpackn_timestamp #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .timestamp               (timestamp),
        .timestamp_every         (timestamp_every),
        .enable                  (enable),
        .fifo_wr_en              (fifo_wr_en),
        .fifo_wr_data            (fifo_wr_data),
        .fifo_wr_overflow        (fifo_wr_overflow),
        .packed_fifo_wr_en       (packed_fifo_wr_en),
        .packed_fifo_wr_sync     (packed_fifo_wr_sync),
        .packed_fifo_wr_ts       (packed_fifo_wr_ts),
        .packed_fifo_wr_data     (packed_fifo_wr_data),
        .packed_fifo_wr_overflow (packed_fifo_wr_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        logic        s;
        logic        t;
        int          c;
    } beat_t;

    beat_t exp_q[$];
    int    ovf_q[$];

    logic [3:0]  m_en = 4'h0;
    int          m_fill = 0;
    int          m_beats = 0;
    int          m_blen = 0;
    logic [63:0] m_acc = '0;
    bit          m_l0first = 1'b0;

    task automatic model_clear();
        m_fill  = 0;
        m_beats = 0;
        m_blen  = 0;
    endtask

    task automatic drop_from(input int e);
        beat_t keep[$];
        int    okeep[$];
        foreach (exp_q[i]) if (exp_q[i].c < e) keep.push_back(exp_q[i]);
        foreach (ovf_q[i]) if (ovf_q[i] < e) okeep.push_back(ovf_q[i]);
        exp_q = keep;
        ovf_q = okeep;
    endtask

    // Set accepted on edge a: header one cycle later if a block opens, k-th enabled sample stored at a+1+k
    task automatic model_set(input logic [63:0] d, input int a);
        int k;
        k = 0;
        if (m_fill == 0 && m_beats == 0 && timestamp_every != 0) begin
            exp_q.push_back('{d: timestamp, s: 1'b1, t: 1'b1, c: a + 1});
            m_blen = int'(timestamp_every);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (m_en[ch]) begin
                if (m_fill == 0) m_l0first = (k == 0);
                m_acc[m_fill*SAMPLE_W +: SAMPLE_W] = d[ch*SAMPLE_W +: SAMPLE_W];
                m_fill++;
                if (m_fill == DATA_W / SAMPLE_W) begin
                    exp_q.push_back('{d: m_acc, s: (timestamp_every == 0) && m_l0first, t: 1'b0, c: a + 1 + k});
                    m_fill = 0;
                    if (m_blen != 0) begin
                        m_beats++;
                        if (m_beats == m_blen) begin
                            m_beats = 0;
                            m_blen  = 0;
                        end
                    end
                end
                k++;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] d, input bit acc, input bit ovf);
        fifo_wr_en   = 1'b1;
        fifo_wr_data = d;
        if (acc) model_set(d, cyc + 1);
        if (ovf) ovf_q.push_back(cyc + 1);
        step(1);
        fifo_wr_en = 1'b0;
    endtask

    task automatic set_en(input logic [3:0] e);
        enable = e;
        if (e != m_en) begin
            drop_from(cyc + 1);
            model_clear();
            m_en = e;
        end
        step(2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drop_from(cyc + 1);
        model_clear();
        step(2);
        reset = 1'b0;
        m_en = enable;
        step(4);
    endtask

    logic [63:0] obs_data = '0;
    logic [63:0] obs_hdr = '0;
    logic        obs_sync = 1'b0;
    logic        obs_ts = 1'b0;
    int          n_beats_seen = 0;
    int          n_hdr_seen = 0;
    int          n_ovf_seen = 0;
    beat_t       cur;
    bit          e_ovf;

    always @(negedge clk) begin
        e_ovf = 1'b0;
        if (ovf_q.size() > 0 && ovf_q[0] == cyc) begin
            e_ovf = 1'b1;
            void'(ovf_q.pop_front());
        end
        check("overflow", fifo_wr_overflow, packed_fifo_wr_overflow | e_ovf);
        if (fifo_wr_overflow && !packed_fifo_wr_overflow) n_ovf_seen++;
        if (packed_fifo_wr_en) begin
            n_beats_seen++;
            if (packed_fifo_wr_ts) begin
                n_hdr_seen++;
                obs_hdr = packed_fifo_wr_data;
            end else begin
                obs_data = packed_fifo_wr_data;
                obs_sync = packed_fifo_wr_sync;
                obs_ts   = packed_fifo_wr_ts;
            end
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %h ts %b sync %b, expected no beat (cycle %0d)",
                         packed_fifo_wr_data, packed_fifo_wr_ts, packed_fifo_wr_sync, cyc);
            end else begin
                cur = exp_q.pop_front();
                check("beat_data", packed_fifo_wr_data, cur.d);
                check("beat_sync", 64'(packed_fifo_wr_sync), 64'(cur.s));
                check("beat_ts", 64'(packed_fifo_wr_ts), 64'(cur.t));
                check("beat_cycle", 64'(cyc), 64'(cur.c));
            end
        end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
            cur = exp_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_beat: got no beat, expected data %h ts %b at cycle %0d (now %0d)",
                     cur.d, cur.t, cur.c, cyc);
        end
    end

    int beats_before;
    int ovf_before;

    initial begin
        reset = 1'b1;
        timestamp = '0;
        timestamp_every = '0;
        enable = 4'h0;
        fifo_wr_en = 1'b0;
        fifo_wr_data = '0;
        packed_fifo_wr_overflow = 1'b0;
        step(3);
        check("rst_wr_en", 64'(packed_fifo_wr_en), 64'd0);
        check("rst_sync", 64'(packed_fifo_wr_sync), 64'd0);
        check("rst_ts", 64'(packed_fifo_wr_ts), 64'd0);
        check("rst_data", packed_fifo_wr_data, 64'd0);
        check("rst_ovf", 64'(fifo_wr_overflow), 64'd0);
        packed_fifo_wr_overflow = 1'b1;
        #1;
        check("rst_ovf_follow", 64'(fifo_wr_overflow), 64'd1);
        packed_fifo_wr_overflow = 1'b0;
        #1;
        reset = 1'b0;
        step(2);

        // 1: four channels, no headers, one set every 5 cycles
        set_en(4'hF);
        repeat (3) begin
            send(64'h4444_3333_2222_1111, 1'b1, 1'b0);
            step(4);
        end
        step(2);
        check("t1_data", obs_data, 64'h4444_3333_2222_1111);
        check("t1_sync", 64'(obs_sync), 64'd1);
        check("t1_ts", 64'(obs_ts), 64'd0);
        check("t1_nbeats", 64'(n_beats_seen), 64'd3);

        // 4: input during the second STORE cycle is dropped with an overflow pulse
        send(64'h1004_1003_1002_1001, 1'b1, 1'b0);
        step(1);
        send(64'hDEAD_DEAD_DEAD_DEAD, 1'b0, 1'b1);
        step(2);
        send(64'h2004_2003_2002_2001, 1'b1, 1'b0);
        step(6);
        check("t4_data", obs_data, 64'h2004_2003_2002_2001);
        check("t4_novf", 64'(n_ovf_seen), 64'd1);
        check("t4_nbeats", 64'(n_beats_seen), 64'd5);

        // 2: sparse enable packs ch0/ch2 of two sets into one beat
        set_en(4'b0101);
        send(64'hDEAD_00A2_BEEF_00A0, 1'b1, 1'b0);
        step(2);
        send(64'hDEAD_00B2_BEEF_00B0, 1'b1, 1'b0);
        step(3);
        check("t2_data", obs_data, 64'h00B2_00B0_00A2_00A0);
        check("t2_sync", 64'(obs_sync), 64'd1);

        // 3: header every 2 data beats
        timestamp_every = 32'd2;
        set_en(4'hF);
        timestamp = 64'h100;
        send(64'h3104_3103_3102_3101, 1'b1, 1'b0);
        step(4);
        timestamp = 64'h180;
        send(64'h3204_3203_3202_3201, 1'b1, 1'b0);
        step(4);
        timestamp = 64'h200;
        send(64'h3304_3303_3302_3301, 1'b1, 1'b0);
        step(5);
        check("t3_nhdr", 64'(n_hdr_seen), 64'd2);
        check("t3_hdr", obs_hdr, 64'h200);
        check("t3_data", obs_data, 64'h3304_3303_3302_3301);
        check("t3_sync", 64'(obs_sync), 64'd0);

        // 5: enable change mid-beat discards it and restarts the block
        timestamp = 64'h300;
        send(64'h5504_5503_5502_5501, 1'b1, 1'b0);
        step(1);
        set_en(4'b0011);
        timestamp = 64'h400;
        send(64'hDEAD_BEEF_5011_5010, 1'b1, 1'b0);
        step(2);
        send(64'hDEAD_BEEF_5021_5020, 1'b1, 1'b0);
        step(3);
        check("t5_nhdr", 64'(n_hdr_seen), 64'd3);
        check("t5_hdr", obs_hdr, 64'h400);
        check("t5_data", obs_data, 64'h5021_5020_5011_5010);

        // 6: reset during STORE, then re-aligned beat, then enable=0 ignores input
        timestamp_every = 32'd0;
        send(64'h0000_0000_6A11_6A10, 1'b1, 1'b0);
        step(2);
        send(64'h0000_0000_6A21_6A20, 1'b1, 1'b0);
        beats_before = n_beats_seen;
        do_reset();
        check("t6_no_strobe", 64'(n_beats_seen), 64'(beats_before));
        send(64'h0000_0000_6011_6010, 1'b1, 1'b0);
        step(2);
        send(64'h0000_0000_6021_6020, 1'b1, 1'b0);
        step(3);
        check("t6_data", obs_data, 64'h6021_6020_6011_6010);
        check("t6_sync", 64'(obs_sync), 64'd1);
        set_en(4'h0);
        beats_before = n_beats_seen;
        ovf_before = n_ovf_seen;
        send(64'h7777_7777_7777_7777, 1'b0, 1'b0);
        step(5);
        check("t6_en0_beats", 64'(n_beats_seen), 64'(beats_before));
        check("t6_en0_ovf", 64'(n_ovf_seen), 64'(ovf_before));

        packed_fifo_wr_overflow = 1'b1;
        #1;
        check("ovf_follow", 64'(fifo_wr_overflow), 64'd1);
        step(2);
        packed_fifo_wr_overflow = 1'b0;
        step(3);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("ovf_q_drained", 64'(ovf_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
